// File: rtl/ashi_reg_pkg.sv
// rtl/ashi_reg_pkg.sv - register map offsets, response codes and CONTROL bit indices for ashi_reg_bank
package ashi_reg_pkg;

    localparam logic [7:0] REG_ID         = 8'h00;
    localparam logic [7:0] REG_CONTROL    = 8'h04;
    localparam logic [7:0] REG_START      = 8'h08;
    localparam logic [7:0] REG_STATUS     = 8'h0C;
    localparam logic [7:0] REG_ADDR_LO    = 8'h10;
    localparam logic [7:0] REG_ADDR_HI    = 8'h14;
    localparam logic [7:0] REG_LENGTH     = 8'h18;
    localparam logic [7:0] REG_BUSY_COUNT = 8'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

endpackage

// File: rtl/ashi_reg_bank_if.sv
// rtl/ashi_reg_bank_if.sv - ASHI write/read strobe interface between AXI4-Lite slave (master) and register bank (slave)
interface ashi_reg_bank_if;
    logic [31:0] ASHI_WADDR;
    logic [31:0] ASHI_WDATA;
    logic        ASHI_WRITE;
    logic        ASHI_WIDLE;
    logic [1:0]  ASHI_WRESP;
    logic [31:0] ASHI_RADDR;
    logic        ASHI_READ;
    logic        ASHI_RIDLE;
    logic [31:0] ASHI_RDATA;
    logic [1:0]  ASHI_RRESP;

    modport master (
        output ASHI_WADDR, ASHI_WDATA, ASHI_WRITE, ASHI_RADDR, ASHI_READ,
        input  ASHI_WIDLE, ASHI_WRESP, ASHI_RIDLE, ASHI_RDATA, ASHI_RRESP
    );

    modport slave (
        input  ASHI_WADDR, ASHI_WDATA, ASHI_WRITE, ASHI_RADDR, ASHI_READ,
        output ASHI_WIDLE, ASHI_WRESP, ASHI_RIDLE, ASHI_RDATA, ASHI_RRESP
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter; clear has priority over increment
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ashi_reg_bank.sv
// rtl/ashi_reg_bank.sv - ASHI register bank for the RDMA transfer engine; RDMA_IRQ_EN adds CONTROL[1] and the irq output
module ashi_reg_bank
    import ashi_reg_pkg::*;
#(
    parameter logic [31:0] ID_VALUE   = 32'h5244_4D41,
    parameter int          ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    ashi_reg_bank_if.slave        bus,
    output logic                  ctrl_enable,
    output logic                  start_pulse,
    output logic [63:0]           xfer_addr,
    output logic [31:0]           xfer_len,
    input  logic                  done_in,
    input  logic                  busy_in
`ifdef RDMA_IRQ_EN
    ,
    output logic                  irq
`endif
);

    logic        ctrl_en;
    logic        ctrl_irq_en;
    logic        done;
    logic [31:0] addr_lo;
    logic [31:0] addr_hi;
    logic [31:0] length;
    logic [31:0] busy_count;

    // Addresses beyond the 2**ADDR_WIDTH byte window are unmapped rather than aliased.
    logic        in_win_w;
    logic        in_win_r;
    logic [7:0]  woff;
    logic [7:0]  roff;
    logic        wr_err;
    logic        wr_ok;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        unused_addr_bits;

    assign in_win_w = (bus.ASHI_WADDR[31:ADDR_WIDTH] == '0);
    assign in_win_r = (bus.ASHI_RADDR[31:ADDR_WIDTH] == '0);
    assign woff     = {bus.ASHI_WADDR[7:2], 2'b00};
    assign roff     = {bus.ASHI_RADDR[7:2], 2'b00};
    assign unused_addr_bits = ^{bus.ASHI_WADDR[1:0], bus.ASHI_RADDR[1:0]};

    assign wr_err = !in_win_w || (woff == REG_ID) || (woff > REG_BUSY_COUNT);
    assign wr_ok  = bus.ASHI_WRITE && !wr_err;

    assign bus.ASHI_WIDLE = ~bus.ASHI_WRITE;
    assign bus.ASHI_RIDLE = ~bus.ASHI_READ;

    assign ctrl_enable = ctrl_en;
    assign xfer_addr   = {addr_hi, addr_lo};
    assign xfer_len    = length;

`ifndef RDMA_IRQ_EN
    assign ctrl_irq_en = 1'b0;
`endif

    always_comb begin
        rd_data = 32'h0;
        rd_resp = RESP_OKAY;
        if (!in_win_r) begin
            rd_resp = RESP_SLVERR;
        end else begin
            case (roff)
                REG_ID:         rd_data = ID_VALUE;
                REG_CONTROL:    rd_data = {30'h0, ctrl_irq_en, ctrl_en};
                REG_START:      rd_data = 32'h0;
                REG_STATUS:     rd_data = {31'h0, done};
                REG_ADDR_LO:    rd_data = addr_lo;
                REG_ADDR_HI:    rd_data = addr_hi;
                REG_LENGTH:     rd_data = length;
                REG_BUSY_COUNT: rd_data = busy_count;
                default:        rd_resp = RESP_SLVERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en        <= 1'b0;
            done           <= 1'b0;
            addr_lo        <= 32'h0;
            addr_hi        <= 32'h0;
            length         <= 32'h0;
            start_pulse    <= 1'b0;
            bus.ASHI_WRESP <= RESP_OKAY;
            bus.ASHI_RDATA <= 32'h0;
            bus.ASHI_RRESP <= RESP_OKAY;
        end else begin
            start_pulse <= wr_ok && (woff == REG_START);
            // Set beats clear when done_in coincides with a W1C write.
            done <= done_in | (done & ~(wr_ok && (woff == REG_STATUS) && bus.ASHI_WDATA[0]));
            if (bus.ASHI_WRITE) begin
                bus.ASHI_WRESP <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (wr_ok) begin
                case (woff)
                    REG_CONTROL: ctrl_en <= bus.ASHI_WDATA[CTRL_ENABLE_BIT];
                    REG_ADDR_LO: addr_lo <= bus.ASHI_WDATA;
                    REG_ADDR_HI: addr_hi <= bus.ASHI_WDATA;
                    REG_LENGTH:  length  <= bus.ASHI_WDATA;
                    default: ;
                endcase
            end
            if (bus.ASHI_READ) begin
                bus.ASHI_RDATA <= rd_data;
                bus.ASHI_RRESP <= rd_resp;
            end
        end
    end

`ifdef RDMA_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_irq_en <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (wr_ok && (woff == REG_CONTROL)) begin
                ctrl_irq_en <= bus.ASHI_WDATA[CTRL_IRQ_EN_BIT];
            end
            irq <= done & ctrl_irq_en;
        end
    end
`endif

    sat_counter #(.WIDTH(32)) u_busy_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (wr_ok && (woff == REG_BUSY_COUNT)),
        .inc   (busy_in & ctrl_en),
        .count (busy_count)
    );

endmodule
